// File: rtl/e_mdu_if.sv
// Handshake/data bundle between the E-stage pipeline logic and the multiply/divide unit.
interface e_mdu_if;
    logic        en;
    logic [2:0]  mdu_op;
    logic        sel_lo;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_rd;

    modport master (
        output en, mdu_op, sel_lo, A, B,
        input  start, busy, hi, lo, mdu_rd
    );

    modport slave (
        input  en, mdu_op, sel_lo, A, B,
        output start, busy, hi, lo, mdu_rd
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit with HI/LO registers.
// Operands are latched at start; the result lands in HI/LO on the last busy edge.
module e_mdu #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  mdu
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_MT    = 3'd7;

    logic [0:0]       state_r;
    logic [CNT_W-1:0] count_r;
    logic             busy_r;
    logic [2:0]       op_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic             start_s;
    logic [31:0]      rd_s;
    logic [63:0]      mul_a_s;
    logic [63:0]      mul_b_s;
    logic [63:0]      prod_s;
    logic [31:0]      div_n_s;
    logic [31:0]      div_d_s;
    logic [31:0]      q_mag_s;
    logic [31:0]      r_mag_s;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             res_wr_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    // Start fires only for a mult/div issued while the unit is idle.
    always_comb begin
        start_s = 1'b0;
        if (mdu.en && (state_r == S_IDLE) && (mdu.mdu_op >= OP_MULT) && (mdu.mdu_op <= OP_DIVU)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // mfhi/mflo read path; driven from the op alone so it does not depend on en.
    always_comb begin
        rd_s = 32'd0;
        case (mdu.mdu_op)
            OP_MFHI: rd_s = hi_r;
            OP_MFLO: rd_s = lo_r;
            default: rd_s = 32'd0;
        endcase
    end

    // Operand conditioning: sign/zero extension for the multiplier, magnitudes for the divider.
    always_comb begin
        mul_a_s = {32'd0, a_r};
        mul_b_s = {32'd0, b_r};
        div_n_s = a_r;
        div_d_s = b_r;
        if (op_r == OP_MULT) begin
            mul_a_s = {{32{a_r[31]}}, a_r};
            mul_b_s = {{32{b_r[31]}}, b_r};
        end else begin
            mul_a_s = {32'd0, a_r};
            mul_b_s = {32'd0, b_r};
        end
        if (op_r == OP_DIV) begin
            div_n_s = abs32(a_r);
            div_d_s = abs32(b_r);
        end else begin
            div_n_s = a_r;
            div_d_s = b_r;
        end
        // A zero divisor never commits, so substitute 1 to keep the divider well defined.
        if (div_d_s == 32'd0) begin
            div_d_s = 32'd1;
        end else begin
            div_d_s = div_d_s;
        end
        prod_s  = mul_a_s * mul_b_s;
        q_mag_s = div_n_s / div_d_s;
        r_mag_s = div_n_s % div_d_s;
    end

    // Result selection from latched operands; divide by zero suppresses the write.
    always_comb begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        res_wr_s = 1'b0;
        case (op_r)
            OP_MULT, OP_MULTU: begin
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_wr_s = 1'b1;
            end
            OP_DIV: begin
                if (b_r != 32'd0) begin
                    res_lo_s = (a_r[31] ^ b_r[31]) ? neg32(q_mag_s) : q_mag_s;
                    res_hi_s = a_r[31] ? neg32(r_mag_s) : r_mag_s;
                    res_wr_s = 1'b1;
                end else begin
                    res_wr_s = 1'b0;
                end
            end
            OP_DIVU: begin
                if (b_r != 32'd0) begin
                    res_lo_s = q_mag_s;
                    res_hi_s = r_mag_s;
                    res_wr_s = 1'b1;
                end else begin
                    res_wr_s = 1'b0;
                end
            end
            default: res_wr_s = 1'b0;
        endcase
    end

    // Control FSM, operand latches and HI/LO update; any op arriving while busy is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_IDLE;
            count_r <= '0;
            busy_r  <= 1'b0;
            op_r    <= 3'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        state_r <= S_BUSY;
                        busy_r  <= 1'b1;
                        count_r <= ((mdu.mdu_op == OP_MULT) || (mdu.mdu_op == OP_MULTU))
                                   ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
                        op_r    <= mdu.mdu_op;
                        a_r     <= mdu.A;
                        b_r     <= mdu.B;
                    end else if (mdu.en && (mdu.mdu_op == OP_MT)) begin
                        if (mdu.sel_lo) begin
                            lo_r <= mdu.A;
                        end else begin
                            hi_r <= mdu.A;
                        end
                    end
                end
                S_BUSY: begin
                    if (count_r == CNT_W'(1)) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        count_r <= '0;
                        if (res_wr_s) begin
                            hi_r <= res_hi_s;
                            lo_r <= res_lo_s;
                        end
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    count_r <= '0;
                end
            endcase
        end
    end

    assign mdu.start  = start_s;
    assign mdu.busy   = busy_r;
    assign mdu.hi     = hi_r;
    assign mdu.lo     = lo_r;
    assign mdu.mdu_rd = rd_s;
endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios plus random mult/div traffic against an arithmetic model.
module tb_e_mdu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    e_mdu_if bus ();

    e_mdu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: HI/LO after an op, from plain 64-bit arithmetic.
    task automatic ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd1: begin r = sa * sb; exp_hi = r[63:32]; exp_lo = r[31:0]; end
            3'd2: begin ur = ua * ub; exp_hi = ur[63:32]; exp_lo = ur[31:0]; end
            3'd3: if (b != 32'd0) begin
                r = sa / sb; exp_lo = r[31:0];
                r = sa % sb; exp_hi = r[31:0];
            end
            3'd4: if (b != 32'd0) begin
                ur = ua / ub; exp_lo = ur[31:0];
                ur = ua % ub; exp_hi = ur[31:0];
            end
            default: ;
        endcase
    endtask

    // Issue one mult/div, count busy cycles, optionally throw illegal ops at it while busy.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit interfere);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] want_rd;
        int n;
        int want_n;
        old_hi = exp_hi;
        old_lo = exp_lo;
        want_n = (op <= 3'd2) ? 5 : 10;
        bus.en = 1'b1; bus.mdu_op = op; bus.sel_lo = 1'b0; bus.A = a; bus.B = b;
        #1;
        chk("start_issue", 32'(bus.start), 32'd1);
        step();
        bus.en = 1'b0; bus.mdu_op = 3'd0; bus.A = $urandom; bus.B = $urandom;
        ref_exec(op, a, b);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            chk("hi_hold", bus.hi, old_hi);
            chk("lo_hold", bus.lo, old_lo);
            if (interfere) begin
                bus.en = 1'b1;
                bus.mdu_op = 3'($urandom_range(1, 7));
                bus.sel_lo = 1'($urandom_range(0, 1));
                bus.A = $urandom;
                bus.B = $urandom;
                #1;
                chk("start_busy", 32'(bus.start), 32'd0);
                want_rd = (bus.mdu_op == 3'd5) ? old_hi : ((bus.mdu_op == 3'd6) ? old_lo : 32'd0);
                chk("rd_busy", bus.mdu_rd, want_rd);
            end
            step();
        end
        bus.en = 1'b0; bus.mdu_op = 3'd0;
        chk("busy_len", 32'(n), 32'(want_n));
        chk("hi_res", bus.hi, exp_hi);
        chk("lo_res", bus.lo, exp_lo);
    endtask

    task automatic do_mt(input logic sel, input logic [31:0] a);
        bus.en = 1'b1; bus.mdu_op = 3'd7; bus.sel_lo = sel; bus.A = a;
        step();
        bus.en = 1'b0; bus.mdu_op = 3'd0;
        if (sel) exp_lo = a; else exp_hi = a;
        chk("mt_hi", bus.hi, exp_hi);
        chk("mt_lo", bus.lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        bus.en = 1'b0; bus.mdu_op = 3'd0; bus.sel_lo = 1'b0; bus.A = 32'd0; bus.B = 32'd0;

        // Reset
        reset = 1'b0;
        repeat (2) step();
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.start), 32'd0);
        reset = 1'b1;
        step();

        // Multiply
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
        do_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("multu_hi_const", bus.hi, 32'h0000_0002);
        chk("multu_lo_const", bus.lo, 32'hFFFF_FFFA);

        // Divide
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        do_op(3'd4, 32'd7, 32'd2, 1'b0);
        chk("divu_lo_const", bus.lo, 32'd3);
        chk("divu_hi_const", bus.hi, 32'd1);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_lo_const", bus.lo, 32'h8000_0000);
        chk("divovf_hi_const", bus.hi, 32'd0);

        // Divide by zero leaves HI/LO alone
        do_mt(1'b0, 32'h11);
        do_mt(1'b1, 32'h22);
        do_op(3'd4, 32'd5, 32'd0, 1'b0);
        chk("dz_hi_const", bus.hi, 32'h11);
        chk("dz_lo_const", bus.lo, 32'h22);

        // mfhi/mflo are independent of en
        bus.mdu_op = 3'd5; #1;
        chk("mfhi_noen", bus.mdu_rd, 32'h11);
        bus.mdu_op = 3'd6; #1;
        chk("mflo_noen", bus.mdu_rd, 32'h22);
        bus.mdu_op = 3'd1; #1;
        chk("start_noen", 32'(bus.start), 32'd0);
        chk("rd_other_op", bus.mdu_rd, 32'd0);
        bus.mdu_op = 3'd0;
        step();

        // Reset in the middle of a multiply
        do_mt(1'b0, 32'hAAAA_0001);
        do_mt(1'b1, 32'hAAAA_0002);
        bus.en = 1'b1; bus.mdu_op = 3'd1; bus.A = 32'd3; bus.B = 32'd4;
        step();
        bus.en = 1'b0; bus.mdu_op = 3'd0;
        chk("mid_busy1", 32'(bus.busy), 32'd1);
        step();
        chk("mid_busy2", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_hi", bus.hi, 32'd0);
        chk("mid_rst_lo", bus.lo, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("late_hi", bus.hi, 32'd0);
            chk("late_lo", bus.lo, 32'd0);
            chk("late_busy", 32'(bus.busy), 32'd0);
        end

        // Busy interlock with illegal traffic
        do_mt(1'b1, 32'h0000_1234);
        do_op(3'd1, 32'h0001_0003, 32'h0002_0005, 1'b1);
        chk("ilk_lo_const", bus.lo, 32'h000B_000F);
        bus.mdu_op = 3'd6; #1;
        chk("ilk_mflo_after", bus.mdu_rd, 32'h000B_000F);
        bus.mdu_op = 3'd0;
        step();

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 4) == 0) do_mt(1'($urandom_range(0, 1)), $urandom);
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
